// File: rtl/ga_pool_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ga_pool_arbiter : single-port sorted-pool memory arbiter (writer + 2 readers)
// Revision 1.0
// ----------------------------------------------------------------------------
module ga_pool_arbiter #(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int WR_BURST_MAX = 4,
  parameter int SIM_DLY      = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sw_rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              a_rd_req,
  input  logic [ADDR_W-1:0] a_rd_addr,
  output logic              a_rd_gnt,
  output logic              a_rd_data_valid,
  output logic [DATA_W-1:0] a_rd_data,
  input  logic              b_rd_req,
  input  logic [ADDR_W-1:0] b_rd_addr,
  output logic              b_rd_gnt,
  output logic              b_rd_data_valid,
  output logic [DATA_W-1:0] b_rd_data,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_rd_data_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              err_orphan_rd,
  output logic [ADDR_W:0]   wr_cnt
);

  localparam int                 BC_W      = (WR_BURST_MAX > 0) ? $clog2(WR_BURST_MAX + 1) : 1;
  localparam logic [BC_W-1:0]    BURST_CAP = BC_W'(WR_BURST_MAX);
  localparam logic [ADDR_W:0]    CNT_MAX   = (ADDR_W + 1)'(DEPTH);

  logic [BC_W-1:0] burst_cnt;
  logic            rr_last;
  logic            pend;
  logic            owner;
  logic            drop;

  logic            rd_any;
  logic            cap_hit;
  logic            rd_slot;
  logic            pick_b;
  logic            ret_ok;

  // SIM_DLY is carried for interface compatibility only; state updates use plain NBAs.
  logic unused_sim_dly;
  assign unused_sim_dly = (SIM_DLY != 0);

  always_comb begin
    rd_any      = a_rd_req | b_rd_req;
    cap_hit     = (WR_BURST_MAX > 0) && (burst_cnt == BURST_CAP) && rd_any;
    wr_gnt      = ~sw_rst & wr_req & ~cap_hit;
    rd_slot     = ~sw_rst & rd_any & (~wr_req | cap_hit);
    // Both readers waiting: the one that did not go last wins.
    pick_b      = b_rd_req & (~a_rd_req | ~rr_last);
    a_rd_gnt    = rd_slot & ~pick_b;
    b_rd_gnt    = rd_slot & pick_b;
    mem_wr_req  = wr_gnt;
    mem_rd_req  = a_rd_gnt | b_rd_gnt;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (wr_gnt) begin
      mem_addr    = wr_addr;
      mem_wr_data = wr_data;
    end else if (a_rd_gnt) begin
      mem_addr = a_rd_addr;
    end else if (b_rd_gnt) begin
      mem_addr = b_rd_addr;
    end
  end

  // A return landing in a soft-reset cycle is discarded along with the tag.
  assign ret_ok          = mem_rd_data_valid & pend & ~sw_rst;
  assign a_rd_data_valid = ret_ok & ~owner;
  assign b_rd_data_valid = ret_ok & owner;
  assign a_rd_data       = a_rd_data_valid ? mem_rd_data : '0;
  assign b_rd_data       = b_rd_data_valid ? mem_rd_data : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      burst_cnt     <= '0;
      rr_last       <= 1'b0;
      pend          <= 1'b0;
      owner         <= 1'b0;
      drop          <= 1'b0;
      err_orphan_rd <= 1'b0;
      wr_cnt        <= '0;
    end else if (sw_rst) begin
      burst_cnt     <= '0;
      rr_last       <= 1'b0;
      pend          <= 1'b0;
      owner         <= 1'b0;
      drop          <= pend;
      err_orphan_rd <= 1'b0;
      wr_cnt        <= '0;
    end else begin
      burst_cnt <= (wr_gnt & rd_any) ? burst_cnt + BC_W'(1) : '0;
      if (a_rd_gnt) begin
        rr_last <= 1'b0;
      end else if (b_rd_gnt) begin
        rr_last <= 1'b1;
      end
      pend  <= mem_rd_req;
      owner <= b_rd_gnt;
      drop  <= 1'b0;
      if (mem_rd_data_valid & ~pend & ~drop) begin
        err_orphan_rd <= 1'b1;
      end
      if (wr_gnt && (wr_cnt != CNT_MAX)) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
